// File: rtl/dmem_bus_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a DMA requester.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_beats
);

  localparam logic [3:0] MaxWait  = 4'(MAX_WAIT);
  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  logic       cpu_req;
  logic       sel_dma;
  logic       in_burst_q, in_burst_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] burst_inc;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign cpu_req = cpu_rd | cpu_wr;

  // Ownership is forced to an idle CPU while reset is held so no beat can slip through.
  always_comb begin
    sel_dma = 1'b0;
    if (reset) begin
      if (in_burst_q && dma_req && (burst_cnt_q < MaxBurst)) begin
        sel_dma = 1'b1;
      end else if (cpu_req && (wait_cnt_q < MaxWait)) begin
        sel_dma = 1'b0;
      end else if (dma_req) begin
        sel_dma = 1'b1;
      end
    end
  end

  assign dma_gnt   = dma_req & sel_dma;
  assign cpu_stall = cpu_req & sel_dma;

  assign mem_rd    = reset & (sel_dma ? ~dma_we : cpu_rd);
  assign mem_wr    = reset & (sel_dma ?  dma_we : cpu_wr);
  assign mem_addr  = sel_dma ? dma_addr  : cpu_addr;
  assign mem_wdata = sel_dma ? dma_wdata : cpu_wdata;

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dma_gnt) begin
      wait_cnt_d = '0;
    end else if (dma_req && (wait_cnt_q < MaxWait)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  assign burst_inc = burst_cnt_q + 8'd1;

  // A grant that reaches MAX_BURST releases the lock; with MAX_BURST = 1 a lock never latches.
  always_comb begin
    in_burst_d  = in_burst_q;
    burst_cnt_d = burst_cnt_q;
    if (in_burst_q) begin
      if (!dma_req || !dma_lock || (dma_gnt && (burst_inc >= MaxBurst))) begin
        in_burst_d  = 1'b0;
        burst_cnt_d = '0;
      end else if (dma_gnt) begin
        burst_cnt_d = burst_inc;
      end
    end else if (dma_gnt && dma_lock && (MaxBurst > 8'd1)) begin
      in_burst_d  = 1'b1;
      burst_cnt_d = 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_burst_q  <= 1'b0;
      burst_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      in_burst_q  <= in_burst_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_beats_q, stat_beats_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_beats_d = stat_beats_q;
    if (stat_clr) begin
      stat_stall_d = '0;
      stat_beats_d = '0;
    end else begin
      if (cpu_stall) stat_stall_d = stat_stall_q + 32'd1;
      if (dma_gnt)   stat_beats_d = stat_beats_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_stall_q <= '0;
      stat_beats_q <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_beats_q <= stat_beats_d;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_beats = stat_beats_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_stall      = '0;
  assign stat_beats      = '0;
`endif

endmodule
